// File: rtl/os_burst_arbiter.sv
// os_burst_arbiter: grants the shared memory bus to one core at a time and
// runs that core's burst. Each core alternates between an add (write) burst
// and an unload (read) burst on successive grants. Arbitration is either
// round-robin or fixed priority (highest index wins).
module os_burst_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned BURST_W   = 6,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned RR_MODE   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CORES-1:0] req,
  input  logic [BURST_W-1:0]   load_len,
  input  logic [BURST_W-1:0]   unload_len,
  input  logic                 mem_ready,
  output logic [NUM_CORES-1:0] grant,
  output logic [BURST_W-1:0]   burst,
  output logic                 add_en,
  output logic                 unload_en,
  output logic                 rw,
  output logic [ADDR_W-1:0]    addr,
  output logic                 beat_valid,
  output logic                 done
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned SHIFT = ADDR_W - IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NUM_CORES-1:0] pend_q, pend_d;
  logic [NUM_CORES-1:0] lphase_q, lphase_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 add_q, add_d;
  logic                 unl_q, unl_d;
  logic                 rw_q, rw_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 bv_q, bv_d;
  logic                 done_q, done_d;

  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_found;
  logic [IDX_W-1:0]     cand;
  logic                 sel_phase;
  logic [BURST_W-1:0]   sel_len;

  function automatic logic [NUM_CORES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] base_addr(input logic [IDX_W-1:0] idx);
    return ADDR_W'(idx) << SHIFT;
  endfunction

  // Pick the winner among pending cores; RR search wraps naturally because
  // NUM_CORES is a power of two and cand is IDX_W bits wide.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
    if (RR_MODE != 0) begin
      for (int unsigned i = 1; i <= NUM_CORES; i++) begin
        cand = last_q + IDX_W'(i);
        if (!arb_found && pend_q[cand]) begin
          arb_found = 1'b1;
          arb_idx   = cand;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (pend_q[i]) begin
          arb_found = 1'b1;
          arb_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Next-state and registered-output logic for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | req;
    lphase_d  = lphase_q;
    last_d    = last_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    add_d     = add_q;
    unl_d     = unl_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    bv_d      = bv_q;
    done_d    = 1'b0;
    sel_phase = lphase_q[arb_idx];
    sel_len   = sel_phase ? unload_len : load_len;

    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) state_d = S_ARB;
      end
      S_ARB: begin
        if (!arb_found) begin
          state_d = S_IDLE;
        end else begin
          win_d             = arb_idx;
          grant_d           = onehot(arb_idx);
          burst_d           = sel_len;
          add_d             = ~sel_phase;
          unl_d             = sel_phase;
          lphase_d[arb_idx] = ~sel_phase;
          cnt_d             = '0;
          if (sel_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            bv_d    = 1'b0;
            rw_d    = 1'b0;
            addr_d  = '0;
          end else begin
            state_d = S_XFER;
            bv_d    = 1'b1;
            rw_d    = sel_phase;
            addr_d  = base_addr(arb_idx);
          end
        end
      end
      S_XFER: begin
        if (mem_ready) begin
          if (cnt_q == burst_q - BURST_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            bv_d    = 1'b0;
            rw_d    = 1'b0;
            addr_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_q + BURST_W'(1);
            addr_d = base_addr(win_q) + ADDR_W'(cnt_q + BURST_W'(1));
          end
        end
      end
      default: begin
        // DONE: release the bus; a fresh request this cycle keeps the bit set.
        state_d = S_IDLE;
        grant_d = '0;
        burst_d = '0;
        add_d   = 1'b0;
        unl_d   = 1'b0;
        last_d  = win_q;
        pend_d  = (pend_q & ~onehot(win_q)) | req;
      end
    endcase
  end

  // State and output registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      lphase_q <= '0;
      last_q   <= IDX_W'(NUM_CORES - 1);
      win_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      add_q    <= 1'b0;
      unl_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      bv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      lphase_q <= lphase_d;
      last_q   <= last_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      add_q    <= add_d;
      unl_q    <= unl_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      bv_q     <= bv_d;
      done_q   <= done_d;
    end
  end

  assign grant      = grant_q;
  assign burst      = burst_q;
  assign add_en     = add_q;
  assign unload_en  = unl_q;
  assign rw         = rw_q;
  assign addr       = addr_q;
  assign beat_valid = bv_q;
  assign done       = done_q;

endmodule

// File: tb/tb_os_burst_arbiter.sv
// Bench for os_burst_arbiter: a round-robin and a fixed-priority instance
// share stimulus; each lane turns issued request sets into an expected
// burst sequence and a monitor checks beats and done pulses against it.
module tb_os_burst_arbiter;

  typedef struct packed {
    logic [1:0] core;
    logic       ph;
    logic [5:0] len;
  } exp_t;

  logic            clk;
  logic            reset_n;
  logic [3:0]      req;
  logic [5:0]      load_len;
  logic [5:0]      unload_len;
  logic            mem_ready;

  logic [1:0][3:0] grant_a;
  logic [1:0][5:0] burst_a;
  logic [1:0][5:0] addr_a;
  logic [1:0]      add_a, unl_a, rw_a, bv_a, done_a;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] issue_mask;
  logic [5:0] issue_load, issue_unl;
  int         issue_cnt = 0;
  int         outst [2];
  logic       mr_pat [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs_all();
    return 64'({grant_a, burst_a, add_a, unl_a, rw_a, addr_a, bv_a, done_a});
  endfunction

  // Reference arbitration: RR searches upward from last winner, else highest index.
  function automatic int pick(input int rr, input logic [3:0] p, input int last);
    if (rr != 0) begin
      for (int i = 1; i <= 4; i++) if (p[(last + i) % 4]) return (last + i) % 4;
    end else begin
      for (int i = 3; i >= 0; i--) if (p[i]) return i;
    end
    return 0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int MODE = (g == 0) ? 1 : 0;

    os_burst_arbiter #(
      .NUM_CORES(4),
      .BURST_W  (6),
      .ADDR_W   (6),
      .RR_MODE  (MODE)
    ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .load_len  (load_len),
      .unload_len(unload_len),
      .mem_ready (mem_ready),
      .grant     (grant_a[g]),
      .burst     (burst_a[g]),
      .add_en    (add_a[g]),
      .unload_en (unl_a[g]),
      .rw        (rw_a[g]),
      .addr      (addr_a[g]),
      .beat_valid(bv_a[g]),
      .done      (done_a[g])
    );

    exp_t       q [$];
    exp_t       e;
    logic [3:0] lm;
    logic [3:0] p;
    logic [3:0] oh;
    logic [5:0] ea;
    int         lastm;
    int         w;
    int         k;
    int         seen;

    initial begin
      lm    = '0;
      lastm = 3;
      k     = 0;
      seen  = 0;
      outst[g] = 0;
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          q.delete();
          k     = 0;
          lm    = '0;
          lastm = 3;
          seen  = issue_cnt;
        end else begin
          if (issue_cnt != seen) begin
            seen = issue_cnt;
            p    = issue_mask;
            while (p != 4'b0) begin
              w      = pick(MODE, p, lastm);
              e.core = 2'(w);
              e.ph   = lm[w];
              e.len  = lm[w] ? issue_unl : issue_load;
              lm[w]  = ~lm[w];
              lastm  = w;
              q.push_back(e);
              p[w]   = 1'b0;
            end
          end
          if (bv_a[g]) begin
            if (q.size() == 0) begin
              check("beat_unexpected", 64'(bv_a[g]), 64'd0);
            end else if (mem_ready) begin
              e  = q[0];
              oh = 4'b0001 << e.core;
              ea = 6'({e.core, 4'b0000} + k);
              check("beat", 64'({grant_a[g], rw_a[g], addr_a[g], add_a[g], unl_a[g]}),
                    64'({oh, e.ph, ea, ~e.ph, e.ph}));
              k++;
            end
          end
          if (done_a[g]) begin
            if (q.size() == 0) begin
              check("done_unexpected", 64'(done_a[g]), 64'd0);
            end else begin
              e  = q.pop_front();
              oh = 4'b0001 << e.core;
              check("done", 64'({grant_a[g], add_a[g], unl_a[g], burst_a[g], 8'(k)}),
                    64'({oh, ~e.ph, e.ph, e.len, 8'(e.len)}));
              k = 0;
            end
          end
        end
        outst[g] = q.size();
      end
    end
  end

  // mem_ready: directed pattern when queued, otherwise random with stalls.
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mr_pat.size() > 0) mem_ready = mr_pat.pop_front();
      else                   mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [3:0] m);
    @(posedge clk);
    #1;
    req        = m;
    issue_mask = m;
    issue_load = load_len;
    issue_unl  = unload_len;
    issue_cnt++;
    @(posedge clk);
    #1;
    req = 4'b0;
  endtask

  task automatic drain();
    repeat (2) begin @(negedge clk); #1; end
    for (int i = 0; i < 3000; i++) begin
      if (outst[0] == 0 && outst[1] == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain", 64'(outst[0] + outst[1]), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_bv();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bv_a[0]) break;
    end
    if (i == 200) check("bv_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    req        = 4'b0;
    load_len   = 6'd3;
    unload_len = 6'd5;
    issue_mask = 4'b0;
    issue_load = '0;
    issue_unl  = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", outs_all(), 64'd0);
    @(negedge clk) reset_n = 1'b1;

    // Single core: add burst, grant two cycles after the request edge.
    issue(4'b0001);
    @(posedge clk);
    #1 check("grant_early", 64'(grant_a[0]), 64'd0);
    @(posedge clk);
    #1 check("grant_latency", 64'({grant_a[0], add_a[0], unl_a[0]}), 64'({4'b0001, 1'b1, 1'b0}));
    drain();
    issue(4'b0001);
    drain();

    // All cores at once, twice; then fixed-priority contrast.
    issue(4'b1111);
    drain();
    issue(4'b1111);
    drain();
    issue(4'b1010);
    drain();

    // Stalled burst with a fixed mem_ready pattern.
    load_len   = 6'd4;
    unload_len = 6'd4;
    issue(4'b0100);
    wait_bv();
    mr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    drain();

    // Zero-length bursts still toggle phase.
    load_len   = 6'd0;
    unload_len = 6'd0;
    issue(4'b1111);
    drain();
    load_len   = 6'd2;
    unload_len = 6'd3;
    issue(4'b0011);
    drain();

    // Random request sets and lengths.
    for (int n = 0; n < 30; n++) begin
      load_len   = 6'($urandom_range(0, 7));
      unload_len = 6'($urandom_range(0, 7));
      issue(4'($urandom_range(1, 15)));
      drain();
    end

    // Reset mid-burst: outputs drop at once, pending work is discarded.
    load_len   = 6'd6;
    unload_len = 6'd6;
    issue(4'b1111);
    wait_bv();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("reset_async", outs_all(), 64'd0);
    repeat (2) @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("idle_after_reset", 64'({grant_a, bv_a, done_a}), 64'd0);
    load_len   = 6'd2;
    unload_len = 6'd7;
    issue(4'b0010);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
